div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle divider sequencer for the execute stage. It accepts a DIV/DIVU request from the execute stage and runs a 32-iteration restoring division. It returns the 64-bit {remainder, quotient} for the HI/LO write path and flags the execute stage to stall while the operation is in flight. It sits beside the execute ALU; its result feeds the execute stage's HI/LO outputs toward the EX/MEM buffer.

## Interface
Parameters: none (widths fixed by `RegBus` = 32 bits).
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by execute stage until result consumed
- annul_i  in  1  abort in-flight division (pipeline flush)
- result_o  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}; registered
- ready_o  out  1  result_o valid; registered
- busy_o  out  1  stall request to execute stage; high in states ON and BYZERO

## Operation
States: IDLE, BYZERO, ON, END. On reset: IDLE, result_o = 0, ready_o = 0, iteration count = 0.
- IDLE, start_i=1 and annul_i=0:
  - opdata2_i == 0 → BYZERO.
  - Otherwise latch operands, clear count, enter ON.
  - When signed: a negative operand is replaced by its two's-complement magnitude; sign flags are latched.
  - start_i=0 or annul_i=1 → stay IDLE.
- BYZERO: next edge → END with result_o = 0, ready_o = 1.
- ON: one iteration per cycle on a 65-bit partial register, initialised to {32'b0, dividend, 1'b0}.
  - Trial subtract divisor from bits [64:32].
  - Borrow → shift left, LSB 0. No borrow → replace the high part with the difference, shift left, LSB 1.
  - After iteration 32 → END. The quotient is the low word and the remainder is the high word shifted right 1.
  - Signed: quotient negated when the operand signs differ; remainder negated when the dividend was negative.
  - INT_MIN / −1 yields quotient 0x80000000, remainder 0.
- ON or BYZERO with annul_i=1 → IDLE immediately. ready_o stays 0 and no result is produced.
- END: ready_o = 1, result_o held.
  - start_i=0 → IDLE, ready_o = 0, result_o = 0.
  - start_i=1 → remain END.
- start_i changes or operand changes during ON are ignored; operands are latched at start.
- rst in any state overrides everything → IDLE with reset values.

## Timing
- Edge E0 samples start_i in IDLE.
- Nonzero divisor: iterations at E1..E32, ready_o rises at E33. The stall spans 33 cycles.
- Zero divisor: BYZERO after E0, ready_o rises at E1.
- busy_o is decoded from registered state. It is high in the cycle after E0 until the state reaches END.
- ready_o falls on the first edge at which start_i=0 is sampled in END.
- Back-to-back operations: the next start_i is accepted no earlier than the cycle after returning to IDLE.

## Configuration
- DIV_SIGNED_EN defined: signed_div_i is honoured, with magnitude conversion and sign correction as above.
- Not defined: signed_div_i is ignored and every division is unsigned. The sign logic is removed.

## Test plan
- Unsigned: 100 / 7 with signed_div_i=0, start at E0.
  - ready_o rises at E33 with result_o = {32'd2, 32'd14}.
  - busy_o is high for cycles E0+1..E32.
- Signed (DIV_SIGNED_EN): −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed (DIV_SIGNED_EN): 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Same −7 / 2 without DIV_SIGNED_EN → quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero: 5 / 0 → ready_o at E1, result_o = 0, returns to IDLE after start_i drops.
- Abort: annul_i pulsed at E10 during ON → IDLE at E10, ready_o never asserts, result_o = 0.
  - A new start at E12 completes normally at E45.
- Reset mid-operation: rst at E20 → IDLE, all outputs 0.
- Hold in END: start_i held 5 cycles after ready → ready_o and result_o stable for 5 cycles.
  - Both clear on the edge that samples start_i=0.

Source files
------------

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider sequencer for the execute stage (32 iterations, HI/LO result).
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every division is unsigned.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [64:0] partial_q, partial_d;
    logic [31:0] divisor_q, divisor_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] trialDiff;
    logic [31:0] dividendMag;
    logic [31:0] divisorMag;
    logic [31:0] quotRaw;
    logic [31:0] remRaw;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;

    assign trialDiff = partial_q[64:32] - {1'b0, divisor_q};
    assign quotRaw   = partial_q[31:0];
    assign remRaw    = partial_q[64:33];

`ifdef DIV_SIGNED_EN
    logic negQuot_q, negQuot_d;
    logic negRem_q, negRem_d;
    logic dividendNeg;
    logic divisorNeg;

    // The core only divides magnitudes; signs are restored once the quotient is final.
    assign dividendNeg = signed_div_i & opdata1_i[31];
    assign divisorNeg  = signed_div_i & opdata2_i[31];
    assign dividendMag = dividendNeg ? (~opdata1_i + 32'd1) : opdata1_i;
    assign divisorMag  = divisorNeg ? (~opdata2_i + 32'd1) : opdata2_i;
    assign quotFinal   = negQuot_q ? (~quotRaw + 32'd1) : quotRaw;
    assign remFinal    = negRem_q ? (~remRaw + 32'd1) : remRaw;
`else
    logic unusedSigned;

    assign unusedSigned = signed_div_i;
    assign dividendMag  = opdata1_i;
    assign divisorMag   = opdata2_i;
    assign quotFinal    = quotRaw;
    assign remFinal     = remRaw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 6'd0;
            partial_q <= 65'd0;
            divisor_q <= 32'd0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            partial_q <= partial_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_SIGNED_EN
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        partial_d = partial_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_SIGNED_EN
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        count_d   = 6'd0;
                        partial_d = {32'd0, dividendMag, 1'b0};
                        divisor_d = divisorMag;
`ifdef DIV_SIGNED_EN
                        negQuot_d = dividendNeg ^ divisorNeg;
                        negRem_d  = dividendNeg;
`endif
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                // The extra pass with count at 32 only publishes the finished result.
                if (annul_i) begin
                    state_d  = IDLE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else if (count_q == 6'd32) begin
                    state_d  = END;
                    result_d = {remFinal, quotFinal};
                    ready_d  = 1'b1;
                end else begin
                    if (trialDiff[32]) begin
                        partial_d = {partial_q[63:0], 1'b0};
                    end else begin
                        partial_d = {trialDiff[31:0], partial_q[31:0], 1'b1};
                    end
                    count_d = count_q + 6'd1;
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = IDLE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q == ON) || (state_q == BYZERO);
    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios plus randomized divisions
// compared against an arithmetic reference model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    // Reference: plain language division; signed mode uses 64-bit arithmetic so INT_MIN / -1 wraps naturally.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic   useSigned;
        useSigned = 1'b0;
`ifdef DIV_SIGNED_EN
        useSigned = sgn;
`endif
        if (b == 32'd0) return 64'd0;
        if (useSigned) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Starts one division and waits (bounded) for ready_o; latency counts edges after E0.
    task automatic runDivision(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input bit scramble, output logic [63:0] res,
                               output int latency, output int busyCnt);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        nextCycle();
        latency = 0;
        busyCnt = 0;
        while (!ready_o && latency < 100) begin
            if (busy_o) busyCnt++;
            if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            nextCycle();
            latency++;
        end
        res = result_o;
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (2) nextCycle();
        compared++;
        if (ready_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ready_o);
        end
        compared++;
        if (result_o !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_result: got %h expected 0", result_o);
        end
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy_o);
        end
        rst = 1'b0;
        nextCycle();
    endtask

    task automatic test_unsigned;
        logic [63:0] res;
        int          lat;
        int          busyCnt;
        runDivision(32'd100, 32'd7, 1'b0, 1'b1, res, lat, busyCnt);
        compared++;
        if (lat !== 33) begin
            mismatched++;
            $display("[TB] FAIL unsigned_latency: got %0d expected 33", lat);
        end
        compared++;
        if (busyCnt !== 33) begin
            mismatched++;
            $display("[TB] FAIL unsigned_busy_cycles: got %0d expected 33", busyCnt);
        end
        compared++;
        if (res !== {32'd2, 32'd14}) begin
            mismatched++;
            $display("[TB] FAIL unsigned_result: got %h expected %h", res, {32'd2, 32'd14});
        end
        start_i = 1'b0;
        nextCycle();
        compared++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL unsigned_release: got ready=%b result=%h busy=%b expected 0/0/0",
                     ready_o, result_o, busy_o);
        end
    endtask

    task automatic test_signed;
        logic [63:0] res;
        logic [63:0] expMinus7;
        logic [63:0] expIntMin;
        int          lat;
        int          busyCnt;
`ifdef DIV_SIGNED_EN
        expMinus7 = {32'hFFFFFFFF, 32'hFFFFFFFD};
        expIntMin = {32'h00000000, 32'h80000000};
`else
        expMinus7 = {32'h00000001, 32'h7FFFFFFC};
        expIntMin = {32'h80000000, 32'h00000000};
`endif
        runDivision(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, res, lat, busyCnt);
        compared++;
        if (res !== expMinus7) begin
            mismatched++;
            $display("[TB] FAIL signed_minus7_div2: got %h expected %h", res, expMinus7);
        end
        start_i = 1'b0;
        nextCycle();
        runDivision(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, res, lat, busyCnt);
        compared++;
        if (res !== expIntMin) begin
            mismatched++;
            $display("[TB] FAIL signed_intmin_div_m1: got %h expected %h", res, expIntMin);
        end
        start_i = 1'b0;
        nextCycle();
        runDivision(32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, res, lat, busyCnt);
        compared++;
        if (res !== {32'h00000001, 32'h7FFFFFFC}) begin
            mismatched++;
            $display("[TB] FAIL divu_minus7_div2: got %h expected %h", res, {32'h00000001, 32'h7FFFFFFC});
        end
        start_i = 1'b0;
        nextCycle();
    endtask

    task automatic test_div_zero;
        logic [63:0] res;
        int          lat;
        int          busyCnt;
        runDivision(32'd5, 32'd0, 1'b0, 1'b0, res, lat, busyCnt);
        compared++;
        if (lat !== 1 || busyCnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL divzero_timing: got latency=%0d busy=%0d expected 1/1", lat, busyCnt);
        end
        compared++;
        if (res !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL divzero_result: got %h expected 0", res);
        end
        start_i = 1'b0;
        nextCycle();
        compared++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL divzero_release: got ready=%b busy=%b expected 0/0", ready_o, busy_o);
        end
        // Annul while waiting in BYZERO must drop back without producing a result.
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        nextCycle();
        compared++;
        if (busy_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL byzero_busy: got %b expected 1", busy_o);
        end
        annul_i = 1'b1;
        nextCycle();
        compared++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL byzero_annul: got ready=%b busy=%b expected 0/0", ready_o, busy_o);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        nextCycle();
    endtask

    task automatic test_abort;
        logic [63:0] res;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          busyCnt;
        opdata1_i    = $urandom;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        nextCycle();
        repeat (9) nextCycle();
        compared++;
        if (busy_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL abort_busy_before: got %b expected 1", busy_o);
        end
        start_i = 1'b0;
        annul_i = 1'b1;
        nextCycle();
        compared++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL abort_idle: got busy=%b ready=%b result=%h expected 0/0/0",
                     busy_o, ready_o, result_o);
        end
        annul_i = 1'b0;
        nextCycle();
        compared++;
        if (ready_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_no_ready: got %b expected 0", ready_o);
        end
        a = $urandom;
        b = $urandom_range(1, 1000);
        runDivision(a, b, 1'b0, 1'b0, res, lat, busyCnt);
        compared++;
        if (lat !== 33 || res !== refDiv(a, b, 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL abort_restart: got latency=%0d result=%h expected 33/%h",
                     lat, res, refDiv(a, b, 1'b0));
        end
        start_i = 1'b0;
        nextCycle();
    endtask

    task automatic test_reset_mid;
        logic [63:0] res;
        int          lat;
        int          busyCnt;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd9;
        start_i   = 1'b1;
        nextCycle();
        repeat (19) nextCycle();
        rst = 1'b1;
        nextCycle();
        compared++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_on: got busy=%b ready=%b result=%h expected 0/0/0",
                     busy_o, ready_o, result_o);
        end
        rst = 1'b0;
        runDivision(32'd1000, 32'd9, 1'b0, 1'b0, res, lat, busyCnt);
        rst = 1'b1;
        nextCycle();
        compared++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_end: got ready=%b result=%h expected 0/0", ready_o, result_o);
        end
        rst     = 1'b0;
        start_i = 1'b0;
        nextCycle();
    endtask

    task automatic test_hold_end;
        logic [63:0] res;
        logic [63:0] expRes;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          busyCnt;
        a      = $urandom;
        b      = $urandom_range(1, 70000);
        expRes = refDiv(a, b, 1'b0);
        runDivision(a, b, 1'b0, 1'b0, res, lat, busyCnt);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            compared++;
            if (ready_o !== 1'b1 || result_o !== expRes) begin
                mismatched++;
                $display("[TB] FAIL hold_end_cycle%0d: got ready=%b result=%h expected 1/%h",
                         i, ready_o, result_o, expRes);
            end
        end
        start_i = 1'b0;
        nextCycle();
        compared++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL hold_end_release: got ready=%b result=%h expected 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          lat;
        int          busyCnt;
        int          sel;
        int          expLat;
        for (int n = 0; n < 30; n++) begin
            a   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 15);
                3: begin
                    a = 32'h80000000;
                    b = 32'hFFFFFFFF;
                end
                4:       b = 32'hFFFFFFFF - $urandom_range(0, 7);
                default: b = $urandom;
            endcase
            expLat = (b == 32'd0) ? 1 : 33;
            runDivision(a, b, sgn, 1'b1, res, lat, busyCnt);
            compared++;
            if (lat !== expLat || busyCnt !== expLat || res !== refDiv(a, b, sgn)) begin
                mismatched++;
                $display("[TB] FAIL random%0d %h/%h s=%b: got lat=%0d busy=%0d result=%h expected %0d/%0d/%h",
                         n, a, b, sgn, lat, busyCnt, res, expLat, expLat, refDiv(a, b, sgn));
            end
            start_i = 1'b0;
            nextCycle();
            compared++;
            if (ready_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL random%0d_release: got ready=%b expected 0", n, ready_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_abort();
        test_reset_mid();
        test_hold_end();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
